mult_share_arb: RTL

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_wallace.sv | 21 ++
 rtl/mult_share_arb.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding and
// default operand/result widths of the shared mult_wallace.
package mult_pkg;
  localparam int OP_W_DEF  = 8;
  localparam int RES_W_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } mult_state_t;
endpackage

// File: rtl/mult_wallace.sv
// Combinational unsigned multiplier; partial products are summed into a
// RES_W-wide result (zero-extended product).
module mult_wallace #(
  parameter int OP_W  = 8,
  parameter int RES_W = 17
) (
  input  logic [OP_W-1:0]  i_a,
  input  logic [OP_W-1:0]  i_b,
  output logic [RES_W-1:0] o_result_final
);
  logic [RES_W-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (i_b[i]) w_acc = w_acc + (RES_W'(i_a) << i);
    end
  end

  assign o_result_final = w_acc;
endmodule

// File: rtl/mult_share_arb.sv
// Two-requester round-robin front end sharing one mult_wallace, one operation
// in flight (IDLE -> CALC -> RESP). MULT_SHARE_ARB_STATS_EN adds grant counters.
module mult_share_arb
  import mult_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OP_W-1:0]  req_a0,
  input  logic [OP_W-1:0]  req_b0,
  input  logic [OP_W-1:0]  req_a1,
  input  logic [OP_W-1:0]  req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_result
`ifdef MULT_SHARE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);
  mult_state_t      r_state, w_next;
  logic [OP_W-1:0]  r_a, r_b;
  logic             r_id, r_last;
  logic [RES_W-1:0] r_rsp_result;
  logic             w_win, w_accept;
  logic [RES_W-1:0] w_prod;

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    w_win     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
    req_ready = 2'b00;
    if (r_state == ST_IDLE && !rst && (|req_valid)) req_ready[w_win] = 1'b1;
    w_accept  = |(req_valid & req_ready);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_CALC;
      ST_CALC: w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last       <= 1'b1;
      r_rsp_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= w_win ? req_a1 : req_a0;
        r_b    <= w_win ? req_b1 : req_b0;
        r_id   <= w_win;
        r_last <= w_win;
      end
      if (r_state == ST_CALC) r_rsp_result <= w_prod;
    end
  end

  mult_wallace #(.OP_W(OP_W), .RES_W(RES_W)) u_mult (
    .i_a            (r_a),
    .i_b            (r_b),
    .o_result_final (w_prod)
  );

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_accept) begin
      if (w_win) r_cnt1 <= r_cnt1 + 1'b1;
      else       r_cnt0 <= r_cnt0 + 1'b1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif
endmodule
